// File: rtl/cnt_pkg.sv
// Shared encodings and defaults for the cnt_bank counter bank.
package cnt_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    typedef enum logic {
        CNT_DN = 1'b0,
        CNT_UP = 1'b1
    } cnt_dir_e;

    localparam int unsigned CNT_DEF_CH = 3;
    localparam int unsigned CNT_DEF_W  = 16;

    // Channel 0 occupies the low slice.
    localparam logic [CNT_DEF_CH*CNT_DEF_W-1:0] CNT_RST_VAL_DEFAULT =
        {16'd333, 16'd222, 16'd111};

endpackage

// File: rtl/cnt_bank_if.sv
// Control and status bundle of the counter bank.
interface cnt_bank_if #(
    parameter int unsigned CH = 3,
    parameter int unsigned W  = 16
);
    logic [CH-1:0]   en;
    logic [CH-1:0]   dir;
    logic [CH-1:0]   mode;
    logic [CH*W-1:0] limit;
    logic [CH-1:0]   load;
    logic [CH*W-1:0] load_val;
    logic [CH*W-1:0] cnt;
    logic [CH-1:0]   tc;
    logic            tick;

    modport master (
        output en, dir, mode, limit, load, load_val,
        input  cnt, tc, tick
    );

    modport slave (
        input  en, dir, mode, limit, load, load_val,
        output cnt, tc, tick
    );
endinterface

// File: rtl/cnt_chan.sv
// One W-bit up/down counter with load, inclusive limit, wrap/saturate and tc pulse.
module cnt_chan
    import cnt_pkg::*;
#(
    parameter int unsigned    W       = 16,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick_i,
    input  logic         en_i,
    input  logic         dir_i,
    input  logic         mode_i,
    input  logic         load_i,
    input  logic [W-1:0] limit_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         tc_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic         tc_q, tc_d;
    logic [W-1:0] cnt_inc;
    logic [W-1:0] cnt_dec;
    logic         sat;

    assign cnt_inc = cnt_q + W'(1);
    assign cnt_dec = cnt_q - W'(1);
    assign sat     = (mode_i == CNT_SAT);

    // Load beats step; >= keeps a lowered limit from running the counter to 2^W.
    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (tick_i && en_i) begin
            if (dir_i == CNT_UP) begin
                if (cnt_q >= limit_i) begin
                    if (sat) begin
                        cnt_d = limit_i;
                    end else begin
                        cnt_d = '0;
                        tc_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_inc;
                    tc_d  = sat && (cnt_inc == limit_i);
                end
            end else begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_dec;
                    tc_d  = sat && (cnt_dec == '0);
                end else if (!sat) begin
                    cnt_d = limit_i;
                    tc_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = tc_q;

endmodule

// File: rtl/cnt_bank.sv
// Bank of CH independent counters stepped by one shared prescaler tick.
module cnt_bank
    import cnt_pkg::*;
#(
    parameter int unsigned          CH       = CNT_DEF_CH,
    parameter int unsigned          W        = CNT_DEF_W,
    parameter logic [CH*W-1:0]      RST_VAL  = CNT_RST_VAL_DEFAULT,
    parameter int unsigned          PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    cnt_bank_if.slave  bus
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]   presc_q, presc_d;
    logic            tick_q, tick_d;
    logic [CH*W-1:0] cnt_w;
    logic [CH-1:0]   tc_w;

    // tick_q is high exactly while presc_q sits at PS_LAST.
    always_comb begin
        presc_d = (presc_q == PS_LAST) ? '0 : presc_q + PW'(1);
        tick_d  = (presc_d == PS_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        cnt_chan #(
            .W       (W),
            .RST_VAL (RST_VAL[i*W +: W])
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_i     (tick_q),
            .en_i       (bus.en[i]),
            .dir_i      (bus.dir[i]),
            .mode_i     (bus.mode[i]),
            .load_i     (bus.load[i]),
            .limit_i    (bus.limit[i*W +: W]),
            .load_val_i (bus.load_val[i*W +: W]),
            .cnt_o      (cnt_w[i*W +: W]),
            .tc_o       (tc_w[i])
        );
    end

    assign bus.cnt  = cnt_w;
    assign bus.tc   = tc_w;
    assign bus.tick = tick_q;

endmodule
